// File: rtl/store_buffer_pkg.sv
// Shared types and defaults for the store buffer and its load-extend helper.
//   data_width_t  : width codes used by both stores and loads
//   sb_entry_t    : one queued store (addr, data, width, valid)
//   DEPTH_DEFAULT : default entry count
//   is_word_store : true when a store width code writes the full word
package store_buffer_pkg;

  typedef enum logic [2:0] {
    W  = 3'b000,
    H  = 3'b001,
    B  = 3'b010,
    HU = 3'b101,
    BU = 3'b110
  } data_width_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  width;
    logic        valid;
  } sb_entry_t;

  localparam int unsigned DEPTH_DEFAULT = 4;

  // Stores only narrow for the half/byte codes; everything else writes a word.
  function automatic logic is_word_store(input logic [2:0] width);
    return (width != H) && (width != B);
  endfunction

endpackage

// File: rtl/store_buffer_load_extend.sv
// Combinational load formatter, also used on the cache read path.
//   word     in  32  aligned source word
//   ld_width in  3   load width code (unknown codes behave as LW)
//   data     out 32  sign/zero-extended result
module load_extend
  import store_buffer_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  ld_width,
  output logic [31:0] data
);

  always_comb begin
    data = word;
    case (ld_width)
      H:       data = {{16{word[15]}}, word[15:0]};
      B:       data = {{24{word[7]}}, word[7:0]};
      HU:      data = {16'h0000, word[15:0]};
      BU:      data = {24'h000000, word[7:0]};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer between the data cache and a slow data memory.
//   st_valid/st_addr/st_data/st_width, st_ready : store enqueue
//   ld_valid/ld_addr/ld_width                   : load lookup
//   fwd_hit/fwd_data, ld_stall                  : lookup result
//   mem_wen/mem_addr/mem_wdata/mem_width,mem_ack: head drain handshake
//   empty                                       : nothing queued
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st_valid,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [2:0]  st_width,
  output logic        st_ready,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  input  logic [2:0]  ld_width,
  output logic        fwd_hit,
  output logic [31:0] fwd_data,
  output logic        ld_stall,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_width,
  input  logic        mem_ack,
  output logic        empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  sb_entry_t       entries_q [DEPTH];
  logic [PtrW-1:0] head_q, tail_q;
  logic [CntW-1:0] count_q;

  logic full, push, pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CntW'(DEPTH));
  assign st_ready = !full;
  assign push     = st_valid && !full;
  assign pop      = mem_ack && !empty;

  // Push and pop never target the same slot: a push needs a free slot and a
  // pop needs an occupied one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      if (push) begin
        entries_q[tail_q] <= '{addr: st_addr, data: st_data, width: st_width, valid: 1'b1};
        tail_q            <= tail_q + 1'b1;
      end
      if (pop) begin
        entries_q[head_q].valid <= 1'b0;
        head_q                  <= head_q + 1'b1;
      end
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  // Drain: present the head entry while anything is queued.
  assign mem_wen   = !empty;
  assign mem_addr  = mem_wen ? entries_q[head_q].addr  : '0;
  assign mem_wdata = mem_wen ? entries_q[head_q].data  : '0;
  assign mem_width = mem_wen ? entries_q[head_q].width : '0;

  // Lookup: scan oldest to youngest so the last hit is the youngest match.
  logic [PtrW-1:0] scan_idx;
  logic            match_found;
  sb_entry_t       match_entry;

  always_comb begin
    scan_idx    = head_q;
    match_found = 1'b0;
    match_entry = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      scan_idx = head_q + PtrW'(i);
      if (entries_q[scan_idx].valid &&
          (entries_q[scan_idx].addr[31:2] == ld_addr[31:2])) begin
        match_found = 1'b1;
        match_entry = entries_q[scan_idx];
      end
    end
  end

  // A younger word store fully covers any older partial one, so only the
  // youngest match decides between forward and stall.
  logic        fwd_ok;
  logic [31:0] ext_data;

  assign fwd_ok   = ld_valid && match_found && is_word_store(match_entry.width) &&
                    (ld_addr[1:0] == 2'b00);
  assign fwd_hit  = fwd_ok;
  assign ld_stall = ld_valid && match_found && !fwd_ok;

  load_extend u_load_extend (
    .word     (match_entry.data),
    .ld_width (ld_width),
    .data     (ext_data)
  );

  assign fwd_data = fwd_ok ? ext_data : '0;

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;
  import store_buffer_pkg::*;

  logic        clk, rst_n;
  logic        st_valid, st_ready;
  logic [31:0] st_addr, st_data;
  logic [2:0]  st_width;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [2:0]  ld_width;
  logic        fwd_hit, ld_stall;
  logic [31:0] fwd_data;
  logic        mem_wen, mem_ack, empty;
  logic [31:0] mem_addr, mem_wdata;
  logic [2:0]  mem_width;

  int n_checks = 0;
  int n_fail   = 0;

  store_buffer #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .st_valid  (st_valid),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_width  (st_width),
    .st_ready  (st_ready),
    .ld_valid  (ld_valid),
    .ld_addr   (ld_addr),
    .ld_width  (ld_width),
    .fwd_hit   (fwd_hit),
    .fwd_data  (fwd_data),
    .ld_stall  (ld_stall),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_width (mem_width),
    .mem_ack   (mem_ack),
    .empty     (empty)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] w);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_width = w;
    tick();
    st_valid = 1'b0;
  endtask

  task automatic drain_one();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_checks++; if (st_ready !== 1'b1) begin n_fail++; $display("FAIL reset_st_ready got %b want 1", st_ready); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", empty); end
    n_checks++; if (mem_wen !== 1'b0) begin n_fail++; $display("FAIL reset_mem_wen got %b want 0", mem_wen); end
    n_checks++; if ({mem_addr, mem_wdata, mem_width} !== 67'd0) begin n_fail++; $display("FAIL reset_mem_bus got %h/%h/%h want 0", mem_addr, mem_wdata, mem_width); end
    n_checks++; if ({fwd_hit, ld_stall, fwd_data} !== 34'd0) begin n_fail++; $display("FAIL reset_lookup got %b/%b/%h want 0", fwd_hit, ld_stall, fwd_data); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_push_drain();
    push_store(32'h100, 32'hDEADBEEF, 3'b000);
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (mem_wen !== 1'b1) begin n_fail++; $display("FAIL hold_mem_wen[%0d] got %b want 1", i, mem_wen); end
      n_checks++; if (mem_addr !== 32'h100 || mem_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL hold_mem_bus[%0d] got %h/%h want 00000100/deadbeef", i, mem_addr, mem_wdata); end
      tick();
    end
    drain_one();
    n_checks++; if (empty !== 1'b1 || mem_wen !== 1'b0) begin n_fail++; $display("FAIL drain_empty got empty=%b wen=%b want 1/0", empty, mem_wen); end
  endtask

  task automatic test_fill_wrap();
    logic [63:0] exp_q[$];
    logic [63:0] head;
    for (int i = 0; i < 4; i++) begin
      push_store(32'h1000 + 32'(4 * i), 32'hA0 + 32'(i), 3'b000);
      exp_q.push_back({32'h1000 + 32'(4 * i), 32'hA0 + 32'(i)});
    end
    n_checks++; if (st_ready !== 1'b0) begin n_fail++; $display("FAIL full_st_ready got %b want 0", st_ready); end
    // Push while full with ack: pop happens, push must be refused.
    st_valid = 1'b1; st_addr = 32'h2000; st_data = 32'h2222; st_width = 3'b000;
    mem_ack  = 1'b1;
    #1;
    n_checks++; if (st_ready !== 1'b0) begin n_fail++; $display("FAIL full_ack_st_ready got %b want 0", st_ready); end
    tick();
    st_valid = 1'b0; mem_ack = 1'b0;
    void'(exp_q.pop_front());
    #1;
    n_checks++; if (mem_addr !== 32'h1004 || st_ready !== 1'b1) begin n_fail++; $display("FAIL refused_push got addr=%h ready=%b want 00001004/1", mem_addr, st_ready); end
    for (int k = 0; k < 10; k++) begin
      st_valid = 1'b1; st_addr = 32'h3000 + 32'(4 * k); st_data = 32'h5000 + 32'(k); st_width = 3'b000;
      mem_ack  = 1'b1;
      #1;
      head = exp_q.pop_front();
      n_checks++; if ({mem_addr, mem_wdata} !== head) begin n_fail++; $display("FAIL wrap_order[%0d] got %h/%h want %h", k, mem_addr, mem_wdata, head); end
      exp_q.push_back({32'h3000 + 32'(4 * k), 32'h5000 + 32'(k)});
      tick();
    end
    st_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      head = exp_q.pop_front();
      n_checks++; if ({mem_addr, mem_wdata} !== head || mem_wen !== 1'b1) begin n_fail++; $display("FAIL tail_order[%0d] got %h/%h wen=%b want %h", k, mem_addr, mem_wdata, mem_wen, head); end
      tick();
    end
    mem_ack = 1'b0;
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL wrap_empty got %b want 1", empty); end
  endtask

  task automatic test_forward();
    logic [2:0]  widths [5] = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b101};
    logic [31:0] expv   [5] = '{32'h000080F0, 32'hFFFF80F0, 32'hFFFFFFF0, 32'h000000F0, 32'h000080F0};
    push_store(32'h200, 32'h000080F0, 3'b000);
    ld_valid = 1'b1; ld_addr = 32'h200;
    for (int i = 0; i < 5; i++) begin
      ld_width = widths[i];
      #1;
      n_checks++; if (fwd_hit !== 1'b1 || ld_stall !== 1'b0 || fwd_data !== expv[i]) begin n_fail++; $display("FAIL fwd_w%b got hit=%b stall=%b data=%h want 1/0/%h", widths[i], fwd_hit, ld_stall, fwd_data, expv[i]); end
    end
    ld_addr = 32'h204; ld_width = 3'b000;
    #1;
    n_checks++; if (fwd_hit !== 1'b0 || ld_stall !== 1'b0) begin n_fail++; $display("FAIL no_match got hit=%b stall=%b want 0/0", fwd_hit, ld_stall); end
    ld_addr = 32'h202; ld_width = 3'b001;
    #1;
    n_checks++; if (fwd_hit !== 1'b0 || ld_stall !== 1'b1) begin n_fail++; $display("FAIL misaligned_ld got hit=%b stall=%b want 0/1", fwd_hit, ld_stall); end
    ld_valid = 1'b0;
    drain_one();
  endtask

  task automatic test_partial();
    push_store(32'h500, 32'h11111111, 3'b000);
    push_store(32'h301, 32'h000000AA, 3'b010);
    ld_valid = 1'b1; ld_addr = 32'h300; ld_width = 3'b000;
    #1;
    n_checks++; if (ld_stall !== 1'b1 || fwd_hit !== 1'b0) begin n_fail++; $display("FAIL partial_stall0 got stall=%b hit=%b want 1/0", ld_stall, fwd_hit); end
    drain_one();
    n_checks++; if (ld_stall !== 1'b1) begin n_fail++; $display("FAIL partial_stall1 got %b want 1", ld_stall); end
    drain_one();
    n_checks++; if (ld_stall !== 1'b0 || fwd_hit !== 1'b0 || empty !== 1'b1) begin n_fail++; $display("FAIL partial_release got stall=%b hit=%b empty=%b want 0/0/1", ld_stall, fwd_hit, empty); end
    ld_valid = 1'b0;
  endtask

  task automatic test_youngest();
    push_store(32'h40, 32'h1, 3'b000);
    push_store(32'h40, 32'h2, 3'b000);
    ld_valid = 1'b1; ld_addr = 32'h40; ld_width = 3'b000;
    #1;
    n_checks++; if (fwd_hit !== 1'b1 || fwd_data !== 32'h2) begin n_fail++; $display("FAIL youngest got hit=%b data=%h want 1/2", fwd_hit, fwd_data); end
    mem_ack = 1'b1;
    #1;
    n_checks++; if (fwd_hit !== 1'b1 || fwd_data !== 32'h2) begin n_fail++; $display("FAIL youngest_popping got hit=%b data=%h want 1/2", fwd_hit, fwd_data); end
    tick();
    mem_ack = 1'b0;
    n_checks++; if (fwd_hit !== 1'b1 || fwd_data !== 32'h2) begin n_fail++; $display("FAIL youngest_after_pop got hit=%b data=%h want 1/2", fwd_hit, fwd_data); end
    drain_one();
    // A store pushed at the same edge is invisible until the next cycle.
    ld_addr = 32'h80;
    st_valid = 1'b1; st_addr = 32'h80; st_data = 32'h1234; st_width = 3'b000;
    #1;
    n_checks++; if (fwd_hit !== 1'b0 || ld_stall !== 1'b0) begin n_fail++; $display("FAIL same_edge_push got hit=%b stall=%b want 0/0", fwd_hit, ld_stall); end
    tick();
    st_valid = 1'b0;
    n_checks++; if (fwd_hit !== 1'b1 || fwd_data !== 32'h1234) begin n_fail++; $display("FAIL next_cycle_fwd got hit=%b data=%h want 1/00001234", fwd_hit, fwd_data); end
    // Younger partial store over a word store blocks forwarding.
    push_store(32'h80, 32'hBEEF, 3'b001);
    n_checks++; if (ld_stall !== 1'b1 || fwd_hit !== 1'b0) begin n_fail++; $display("FAIL younger_partial got stall=%b hit=%b want 1/0", ld_stall, fwd_hit); end
    ld_valid = 1'b0;
    drain_one();
    drain_one();
  endtask

  task automatic test_reset_mid();
    push_store(32'h600, 32'h6, 3'b000);
    push_store(32'h604, 32'h7, 3'b000);
    push_store(32'h608, 32'h8, 3'b000);
    n_checks++; if (mem_wen !== 1'b1 || mem_addr !== 32'h600) begin n_fail++; $display("FAIL pre_reset got wen=%b addr=%h want 1/00000600", mem_wen, mem_addr); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (mem_wen !== 1'b0 || empty !== 1'b1 || mem_addr !== 32'h0) begin n_fail++; $display("FAIL async_reset got wen=%b empty=%b addr=%h want 0/1/0", mem_wen, empty, mem_addr); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_checks++; if (empty !== 1'b1 || mem_wen !== 1'b0 || st_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset got empty=%b wen=%b ready=%b want 1/0/1", empty, mem_wen, st_ready); end
  endtask

  initial begin
    rst_n = 1'b0;
    st_valid = 1'b0; st_addr = '0; st_data = '0; st_width = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_width = '0;
    mem_ack = 1'b0;
    test_reset();
    test_push_drain();
    test_fill_wrap();
    test_forward();
    test_partial();
    test_youngest();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write buffer between the data cache and data memory. Word-granular stores that the cache has already accepted are queued here and drained to a slow data memory through a req/ack handshake, so the CPU never waits on memory write latency. Loads are checked against queued stores: exact full-word matches are forwarded, and partial overlaps stall the load until the buffer drains past them.

## Interface
- `DEPTH`, 4: entry count; power of two, at least 2.
- `clk`  in  1  system clock, all state updates on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `st_valid`  in  1  store request from the CPU/cache stage.
- `st_addr`  in  32  store byte address.
- `st_data`  in  32  store data, right-aligned.
- `st_width`  in  3  DataWidth code: 000 word, 001 half, 010 byte; any other code is treated as word.
- `st_ready`  out  1  buffer can accept a store this cycle (`!full`).
- `ld_valid`  in  1  load lookup request.
- `ld_addr`  in  32  load byte address.
- `ld_width`  in  3  DataWidth code: 000 LW, 001 LH, 010 LB, 101 LHU, 110 LBU; any other code is treated as LW.
- `fwd_hit`  out  1  `fwd_data` is valid and replaces memory/cache data.
- `fwd_data`  out  32  forwarded load data, extended per `ld_width`.
- `ld_stall`  out  1  load overlaps a non-forwardable queued store; hold the pipeline.
- `mem_wen`  out  1  write request to data memory.
- `mem_addr`  out  32  head entry address.
- `mem_wdata`  out  32  head entry data.
- `mem_width`  out  3  head entry width code.
- `mem_ack`  in  1  memory accepts the head write at this posedge.
- `empty`  out  1  no queued entries; used for fences and `ecall`.

## Operation
- Circular FIFO with head/tail pointers of `$clog2(DEPTH)` bits plus a count of `$clog2(DEPTH)+1` bits. Each entry holds addr, data, width and valid.
- **Push:** on `st_valid && st_ready`, the entry is written at the tail and tail increments, wrapping from `DEPTH-1` to 0.
- **Drain:** when not empty, `mem_wen`=1 and the mem_* outputs present the head entry. On `mem_ack`, head increments and the entry is invalidated. `mem_ack` while empty is ignored.
- **Push and pop in the same cycle:** count is unchanged. When full, `st_ready`=0 even if `mem_ack` is high; there is no pass-through.
- **Word match:** an entry matches when `entry.addr[31:2] == ld_addr[31:2]`.
- **Forward:** if the youngest matching entry has width 000, `ld_addr[1:0]`=00, and no partial-width matching entry is younger than it, then `fwd_hit`=1. `fwd_data` is the entry data, formatted as follows.
  - LW: the full word.
  - LH: sign-extended from bit 15.
  - LB: sign-extended from bit 7.
  - LHU and LBU: zero-extended.
- **Stall:** any other match with `ld_valid`=1 gives `ld_stall`=1 and `fwd_hit`=0.
- **No match:** `fwd_hit`=0 and `ld_stall`=0; the load is served by the cache or memory.
- Lookup is purely combinational against pre-edge contents. An entry popped at the same edge still counts this cycle. A store pushed at the same edge is not visible until the next cycle.

## Timing
- Reset values: `st_ready`=1, `empty`=1, `mem_wen`=0, mem_* = 0, `fwd_hit`=0, `ld_stall`=0, `fwd_data`=0. All pointers, counts and valids are 0.
- Reset is asynchronous. Asserting it mid-drain discards all entries and drops `mem_wen` immediately, without waiting for a clock edge.
- Store-to-memory latency: a push into an empty buffer at edge N raises `mem_wen` in the cycle after N.
- The mem_* outputs are stable while `mem_wen`=1 and `mem_ack`=0. The next entry appears in the cycle after the ack edge, so back-to-back drains run at one entry per cycle when `mem_ack` is held high.
- `st_ready`, `empty`, `fwd_hit` and `ld_stall` have no combinational path from `mem_ack` or `st_valid`.

## Structure
- Package `store_buffer_pkg` holds:
  - the `data_width_t` enum (W=000, H=001, B=010, HU=101, BU=110);
  - the `sb_entry_t` struct (addr, data, width, valid);
  - the `DEPTH` default.
- One sub-module, `load_extend`, is combinational: word plus `ld_width` in, extended data out. It is shared with the cache read path.

## Test plan
- **Push/drain:** reset, push sw 0x100←0xDEADBEEF, hold `mem_ack`=0 for 3 cycles → `mem_wen`=1 with addr 0x100 stable across all 3. Ack once → `empty`=1 on the next cycle.
- **Fill and wrap:** push 4 words with `mem_ack`=0 → `st_ready`=0. Push attempt with `mem_ack`=1 is refused. Then push/pop continuously for 10 entries → drain order matches push order across pointer wrap.
- **Forwarding:** queue sw 0x200←0x0000_80F0, then load with `ld_addr`=0x200 →
  - LW gives 0x000080F0;
  - LH gives 0xFFFF80F0;
  - LB gives 0xFFFFFFF0;
  - LBU gives 0x000000F0;
  - `fwd_hit`=1 for each.
- **Partial overlap:** queue sb 0x301←0xAA, load LW 0x300 → `ld_stall`=1 until that entry acks, then `ld_stall`=0 and `fwd_hit`=0.
- **Youngest wins:** queue sw 0x40←1 then sw 0x40←2, load 0x40 → `fwd_data`=2. Lookup in the same cycle the older entry pops still returns 2.
- **Reset mid-operation:** 3 entries queued and `mem_wen`=1, assert `rst_n`=0 asynchronously → `mem_wen`=0 before the next edge. After release, `empty`=1.
